shift_seq8: RTL and testbench
=============================

Name: shift_seq8

Overview:
Command sequencer that drives the 8-bit shifter's op/shamt/d_in interface as its initiator and reads back its registered d_out.
- Accepts one request {data, direction, amount 0..7}, issues LOAD, then as many shift ops (shamt ≤ 3 each) as the amount needs.
- Captures the final shifter output and reports it with a one-cycle done pulse.
- Sits between control logic and the shifter8 instance.

Parameters:
MAX_STEP, 3, largest shamt issued per shift op (fixed by the shifter's 2-bit shamt)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request strobe, sampled in IDLE only
cmd_dir  input  2  00 LSL, 01 LSR, 10 ASR, 11 reserved
cmd_amt  input  3  total shift amount 0..7
cmd_data  input  8  value to load
busy  output  1  high while a request is in progress
done  output  1  one-cycle pulse; result valid
result  output  8  final shifted value, held until next done
err  output  1  one-cycle pulse when start carries cmd_dir=11
sh_op  output  3  to shifter op: NOP 000, LOAD 001, LSL 010, LSR 011, ASR 100
sh_shamt  output  2  to shifter shamt
sh_d_in  output  8  to shifter d_in
sh_d_out  input  8  from shifter registered d_out

Behaviour:
- One clock. Reset is synchronous and active-high. The clock port is clk and the reset port is reset.
- Reset values: state IDLE, busy 0, done 0, err 0, result 8'h00, rem 0, captured dir/data 0, sh_op NOP, sh_shamt 0, sh_d_in 0. Reset mid-request aborts it, so the shifter sees NOP from the next cycle and no done is produced.
- Registered FSM, Moore outputs: IDLE, LOAD, SHIFT, DONE.
- IDLE: sh_op=NOP.
  - start=1 with cmd_dir≠11: capture data/dir/amt (rem←amt) and go to LOAD.
  - start=1 with cmd_dir=11: err=1 next cycle, stay IDLE, no shifter activity.
- LOAD (1 cycle): sh_op=LOAD, sh_d_in=captured data. Next state is SHIFT if rem≠0, else DONE.
- SHIFT: sh_op=dir-mapped shift op, sh_shamt=min(rem,3), rem←rem−sh_shamt. When rem−sh_shamt=0, next state is DONE; otherwise stay in SHIFT.
- DONE (1 cycle): sh_op=NOP; result←sh_d_out; done←1 next cycle; return to IDLE.
- Shift cycles N = ceil(amt/3): amt 0→0, 1..3→1, 4..6→2, 7→3. Split order is always greedy 3s first (7 = 3,3,1).
- Timing, with start sampled at edge E0:
  - LOAD in cycle 1.
  - SHIFT in cycles 2..N+1.
  - DONE in cycle N+2.
  - done=1 and result valid in cycle N+3.
  - busy=1 in cycles 1..N+2.
- start while busy is ignored, including during DONE. start in the done cycle (IDLE) is accepted.
- cmd_* inputs are don't-care after capture.
- sh_d_in holds the captured data outside LOAD. sh_shamt=0 outside SHIFT.
- Width rules: rem is 3 bits unsigned. The sequencer does no arithmetic on the data; the shift semantics are the shifter's (LSL/LSR zero-fill, ASR sign-fill).

Decomposition:
- Shared package: shifter op codes (NOP, LOAD, LSL, LSR, ASR), dir encodings, FSM state encoding, MAX_STEP.
- No sub-module inside the block.
- Bench top instantiates shift_seq8 connected to shifter8 so the results below are end-to-end.

Test Plan:
- cmd_dir=00, cmd_amt=5, cmd_data=8'h81 → sh_shamt sequence 3,2; done in cycle 5; result=8'h20.
- cmd_dir=10, cmd_amt=7, cmd_data=8'h80 → shamt 3,3,1; done in cycle 6; result=8'hFF. Repeat with data 8'h40 → 8'h00.
- cmd_dir=01, cmd_amt=4, cmd_data=8'hF0 → result=8'h0F. Pulse start every cycle while busy → exactly one done; second request accepted only in the done cycle.
- cmd_amt=0, cmd_data=8'h5A, dir 00 → LOAD then DONE, no shift op; done in cycle 3; result=8'h5A.
- cmd_dir=11 → err=1 for one cycle, busy stays 0, sh_op stays NOP, result unchanged.
- Assert reset during SHIFT of an amt=7 request → next cycle busy=0, sh_op=NOP, result=8'h00, no done. A following request completes normally.

Source files
------------

// File: rtl/shift_seq8_pkg.sv
// shift_seq8_pkg: shifter op codes, direction codes, sequencer states and split helpers
package shift_seq8_pkg;
  localparam int MAX_STEP = 3;
  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_LSL  = 3'b010,
    OP_LSR  = 3'b011,
    OP_ASR  = 3'b100
  } sh_op_e;
  typedef enum logic [1:0] {
    DIR_LSL = 2'b00,
    DIR_LSR = 2'b01,
    DIR_ASR = 2'b10,
    DIR_RSV = 2'b11
  } dir_e;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;
  // Greedy split: take the largest shamt the shifter accepts, remainder last.
  function automatic logic [1:0] step_of(input logic [2:0] rem);
    return (rem > 3'(MAX_STEP)) ? 2'(MAX_STEP) : rem[1:0];
  endfunction
  function automatic sh_op_e op_of(input logic [1:0] dir);
    return (dir == DIR_LSL) ? OP_LSL : (dir == DIR_LSR) ? OP_LSR : OP_ASR;
  endfunction
endpackage

// File: rtl/shift_seq8.sv
// shift_seq8: sequences LOAD plus greedy shift ops into an 8-bit shifter and reports the result
module shift_seq8
  import shift_seq8_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] cmd_dir,
  input  logic [2:0] cmd_amt,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       err,
  output logic [2:0] sh_op,
  output logic [1:0] sh_shamt,
  output logic [7:0] sh_d_in,
  input  logic [7:0] sh_d_out
);
  state_e      state_q;
  sh_op_e      sh_op_q;
  logic [2:0]  rem_q;
  logic [1:0]  dir_q;
  logic [7:0]  sh_d_in_q;
  logic [7:0]  result_q;
  logic [1:0]  sh_shamt_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [1:0]  step_d;
  logic [2:0]  rem_d;
  assign step_d   = step_of(rem_q);
  assign rem_d    = rem_q - {1'b0, step_d};
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign err      = err_q;
  assign sh_op    = sh_op_q;
  assign sh_shamt = sh_shamt_q;
  assign sh_d_in  = sh_d_in_q;
  // Sequencer FSM; all outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sh_op_q    <= OP_NOP;
      rem_q      <= '0;
      dir_q      <= '0;
      sh_d_in_q  <= '0;
      result_q   <= '0;
      sh_shamt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && cmd_dir == DIR_RSV) begin
            err_q <= 1'b1;
          end else if (start) begin
            state_q   <= S_LOAD;
            sh_op_q   <= OP_LOAD;
            busy_q    <= 1'b1;
            dir_q     <= cmd_dir;
            rem_q     <= cmd_amt;
            sh_d_in_q <= cmd_data;
          end
        end
        S_LOAD, S_SHIFT: begin
          if (rem_q == 3'd0) begin
            state_q    <= S_DONE;
            sh_op_q    <= OP_NOP;
            sh_shamt_q <= '0;
          end else begin
            state_q    <= S_SHIFT;
            sh_op_q    <= op_of(dir_q);
            sh_shamt_q <= step_d;
            rem_q      <= rem_d;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          result_q <= sh_d_out;
          done_q   <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_seq8.sv
// tb_shift_seq8: end-to-end check of shift_seq8 driving a behavioural 8-bit shifter
module tb_shift_seq8;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] cmd_dir = '0;
  logic [2:0] cmd_amt = '0;
  logic [7:0] cmd_data = '0;
  logic       busy, done, err;
  logic [7:0] result, sh_d_in, sh_d_out;
  logic [2:0] sh_op;
  logic [1:0] sh_shamt;
  int total = 0;
  int bad = 0;

  shift_seq8 dut (
    .clk(clk), .reset(reset), .start(start), .cmd_dir(cmd_dir), .cmd_amt(cmd_amt),
    .cmd_data(cmd_data), .busy(busy), .done(done), .result(result), .err(err),
    .sh_op(sh_op), .sh_shamt(sh_shamt), .sh_d_in(sh_d_in), .sh_d_out(sh_d_out)
  );

  always #5 clk = ~clk;

  // Behavioural shifter8: registered d_out, NOP holds.
  always_ff @(posedge clk) begin
    if (reset) sh_d_out <= '0;
    else if (sh_op == 3'b001) sh_d_out <= sh_d_in;
    else if (sh_op == 3'b010) sh_d_out <= sh_d_out << sh_shamt;
    else if (sh_op == 3'b011) sh_d_out <= sh_d_out >> sh_shamt;
    else if (sh_op == 3'b100) sh_d_out <= 8'($signed(sh_d_out) >>> sh_shamt);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: shift one bit at a time, amt times, with the direction's fill rule.
  function automatic logic [7:0] ref_shift(input logic [1:0] d, input logic [2:0] a, input logic [7:0] v);
    logic [7:0] r = v;
    for (int i = 0; i < int'(a); i++)
      r = (d == 2'd0) ? {r[6:0], 1'b0} : (d == 2'd1) ? {1'b0, r[7:1]} : {r[7], r[7:1]};
    return r;
  endfunction

  // One full request: start sampled at E0, then watch cycles 1.. until done.
  task automatic run_req(input logic [1:0] d, input logic [2:0] a, input logic [7:0] v, input logic [7:0] exp);
    int n = (int'(a) + 2) / 3;
    int si = 0;
    int rem = int'(a);
    bit got = 0;
    logic [2:0] op_exp = (d == 2'd0) ? 3'b010 : (d == 2'd1) ? 3'b011 : 3'b100;
    @(negedge clk);
    start = 1'b1; cmd_dir = d; cmd_amt = a; cmd_data = v;
    @(negedge clk);
    start = 1'b0; cmd_data = 8'($urandom); cmd_amt = 3'($urandom); cmd_dir = 2'($urandom);
    chk("load_op", sh_op, 3'b001);
    chk("load_din", sh_d_in, v);
    chk("load_busy", busy, 1'b1);
    for (int c = 2; c <= 15 && !got; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        chk("done_cycle", c, n + 3);
        chk("result", result, exp);
        chk("busy_after", busy, 1'b0);
      end else begin
        chk("busy_during", busy, 1'b1);
        if (sh_op != 3'b000) begin
          chk("shift_op", sh_op, op_exp);
          chk("shamt", sh_shamt, (rem > 3) ? 3 : rem);
          rem -= (rem > 3) ? 3 : rem;
          si++;
        end else chk("shamt_idle", sh_shamt, 0);
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    chk("shift_count", si, n);
  endtask

  typedef struct {
    logic [1:0] dir;
    logic [2:0] amt;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int dones;
    int loads;
    tbl[0] = '{2'b00, 3'd5, 8'h81, 8'h20};
    tbl[1] = '{2'b10, 3'd7, 8'h80, 8'hFF};
    tbl[2] = '{2'b10, 3'd7, 8'h40, 8'h00};
    tbl[3] = '{2'b01, 3'd4, 8'hF0, 8'h0F};
    tbl[4] = '{2'b00, 3'd0, 8'h5A, 8'h5A};
    tbl[5] = '{2'b01, 3'd3, 8'hA5, 8'h14};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_op", sh_op, 0);
    chk("rst_shamt", sh_shamt, 0);
    chk("rst_din", sh_d_in, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_req(tbl[i].dir, tbl[i].amt, tbl[i].data, tbl[i].exp);

    // Reserved direction: err pulse only, nothing else moves.
    @(negedge clk);
    start = 1'b1; cmd_dir = 2'b11; cmd_amt = 3'd5; cmd_data = 8'h33;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_op", sh_op, 0);
    chk("err_result", result, 8'h14);
    @(negedge clk);
    chk("err_clear", err, 0);
    chk("err_op2", sh_op, 0);

    // Start held high while busy: one done, next request taken only in the done cycle.
    @(negedge clk);
    start = 1'b1; cmd_dir = 2'b01; cmd_amt = 3'd4; cmd_data = 8'hF0;
    @(negedge clk);
    cmd_dir = 2'b00; cmd_amt = 3'd1; cmd_data = 8'h03;
    dones = 0; loads = 0;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      if (done) dones++;
      if (sh_op == 3'b001) loads++;
      if (c == 5) chk("spam_result", result, 8'h0F);
    end
    chk("spam_dones", dones, 1);
    chk("spam_no_reload", loads, 0);
    @(negedge clk);
    start = 1'b0;
    chk("spam_second_load", sh_op, 3'b001);
    chk("spam_second_din", sh_d_in, 8'h03);
    dones = 0;
    for (int c = 0; c < 8 && dones == 0; c++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        chk("spam_second_result", result, 8'h06);
      end
    end
    chk("spam_second_done", dones, 1);

    // Reset during SHIFT aborts the request.
    @(negedge clk);
    start = 1'b1; cmd_dir = 2'b10; cmd_amt = 3'd7; cmd_data = 8'h80;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_in_shift", sh_op, 3'b100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_op", sh_op, 0);
    chk("abort_result", result, 0);
    chk("abort_done", done, 0);
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    run_req(2'b00, 3'd2, 8'h11, 8'h44);

    // Random requests against the bitwise reference.
    for (int i = 0; i < 25; i++) begin
      logic [1:0] d = 2'($urandom_range(0, 2));
      logic [2:0] a = 3'($urandom);
      logic [7:0] v = 8'($urandom);
      run_req(d, a, v, ref_shift(d, a, v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
